fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register feeding decode.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack handshake between the fetch stage and instruction memory.
// The fetch stage holds req with a stable addr until a one-cycle ack returns rdata.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one fetch in flight at most, buffers a word caught by a stall, and drops fetches killed by a redirect.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_FETCH | request at pc_q outstanding (or first cycle after reset, idle)
//   ST_HOLD  | fetched word parked in hold_q while decode is stalled, no request
//   ST_DROP  | redirected; waiting for ack of the stale request, then jump to pend_pc_q
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic [31:0]   instruction,
    output logic [31:0]   pc_id,
    output logic [31:0]   pc_plus4_id,
    output logic          valid_id
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        live_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] insn_d, pc_id_d, pc4_id_d;
    logic        valid_d;
    logic        req;
    logic        ack;
    logic [31:0] redirect_al;
    logic [31:0] pc_q_plus4;

    // live_q keeps req low for the first cycle after reset release
    assign req            = live_q && (state_q != ST_HOLD);
    assign ack            = imem.imem_ack && req;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign redirect_al    = {redirect_pc[31:2], 2'b00};
    assign pc_q_plus4     = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_d    = hold_q;
        hold_pc_d = hold_pc_q;
        pend_pc_d = pend_pc_q;
        insn_d    = instruction;
        pc_id_d   = pc_id;
        pc4_id_d  = pc_plus4_id;
        valid_d   = valid_id;

        case (state_q)
            ST_FETCH: begin
                if (!live_q) begin
                    if (flush) pc_d = redirect_al;
                    if (flush || !stall) begin
                        valid_d = 1'b0;
                        insn_d  = NOP_INSN;
                    end
                end else if (ack) begin
                    if (flush) begin
                        pc_d    = redirect_al;
                        valid_d = 1'b0;
                        insn_d  = NOP_INSN;
                    end else if (!stall) begin
                        insn_d   = imem.imem_rdata;
                        pc_id_d  = pc_q;
                        pc4_id_d = pc_q_plus4;
                        valid_d  = 1'b1;
                        pc_d     = pc_q_plus4;
                    end else begin
                        hold_d    = imem.imem_rdata;
                        hold_pc_d = pc_q;
                        pc_d      = pc_q_plus4;
                        state_d   = ST_HOLD;
                    end
                end else if (flush) begin
                    pend_pc_d = redirect_al;
                    state_d   = ST_DROP;
                    valid_d   = 1'b0;
                    insn_d    = NOP_INSN;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    insn_d  = NOP_INSN;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    pc_d    = redirect_al;
                    state_d = ST_FETCH;
                    valid_d = 1'b0;
                    insn_d  = NOP_INSN;
                end else if (!stall) begin
                    insn_d   = hold_q;
                    pc_id_d  = hold_pc_q;
                    pc4_id_d = hold_pc_q + 32'd4;
                    valid_d  = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_DROP: begin
                // a redirect arriving with the stale ack still wins
                if (flush) pend_pc_d = redirect_al;
                if (ack) begin
                    pc_d    = flush ? redirect_al : pend_pc_q;
                    state_d = ST_FETCH;
                end
                if (flush || !stall) begin
                    valid_d = 1'b0;
                    insn_d  = NOP_INSN;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FETCH;
            live_q      <= 1'b0;
            pc_q        <= RESET_PC;
            hold_q      <= 32'h0;
            hold_pc_q   <= 32'h0;
            pend_pc_q   <= 32'h0;
            instruction <= NOP_INSN;
            pc_id       <= 32'h0;
            pc_plus4_id <= 32'h0;
            valid_id    <= 1'b0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            hold_pc_q   <= hold_pc_d;
            pend_pc_q   <= pend_pc_d;
            instruction <= insn_d;
            pc_id       <= pc_id_d;
            pc_plus4_id <= pc4_id_d;
            valid_id    <= valid_d;
        end
    end

endmodule
